// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: splits CPU data accesses between DMEM and six
// memory-mapped peripheral slots, posts peripheral writes, stalls the CPU
// on peripheral reads, bounds every peripheral wait with a timeout and
// exposes sticky error bits through a status register at offset 0x8F0.
module mmio_bus_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_re,
   output logic        stall,
   output logic [31:0] cpu_rdata,
   output logic        dmem_we,
   output logic [5:0]  per_req,
   output logic        per_we,
   output logic [31:0] per_wdata,
   input  logic [5:0]  per_ack,
   input  logic [31:0] per_rdata
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WR_BUSY = 2'd1;
   localparam logic [1:0] S_RD_BUSY = 2'd2;
   localparam logic [1:0] S_RD_DONE = 2'd3;

   // Last counter value before a transaction is abandoned.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state;
   logic [2:0]  slot_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [7:0]  cnt_q;
   logic [5:0]  per_req_q;
   logic        unmapped_err;
   logic        timeout_err;

   logic [11:0] off;
   logic        hi;
   logic        acc;
   logic        slot_hit;
   logic [2:0]  slot_dec;
   logic        is_status;
   logic        per_acc;
   logic        unm_acc;
   logic        stat_rd;
   logic        stat_wr;
   logic        busy;
   logic        act_ack;
   logic        tmo_hit;
   logic        stall_c;
   logic        unused_addr;

   // Only the low 12 address bits take part in decoding.
   assign unused_addr = ^cpu_addr[31:12];

   assign off       = cpu_addr[11:0];
   assign hi        = cpu_addr[11];
   assign acc       = cpu_we | cpu_re;
   assign is_status = (off == 12'h8F0);

   // Peripheral slot decode from the page offset.
   always_comb begin
      slot_hit = 1'b1;
      slot_dec = 3'd0;
      case (off)
         12'h800: slot_dec = 3'd0;
         12'h804: slot_dec = 3'd1;
         12'h814: slot_dec = 3'd2;
         12'h81C: slot_dec = 3'd3;
         12'h82C: slot_dec = 3'd4;
         12'h830: slot_dec = 3'd5;
         default: slot_hit = 1'b0;
      endcase
   end

   // A write strobe always wins over a read strobe.
   assign per_acc = hi & slot_hit & acc;
   assign unm_acc = hi & ~slot_hit & ~is_status & acc;
   assign stat_rd = hi & is_status & cpu_re & ~cpu_we;
   assign stat_wr = hi & is_status & cpu_we;

   assign busy    = (state == S_WR_BUSY) | (state == S_RD_BUSY);
   assign act_ack = per_ack[slot_q];
   assign tmo_hit = (cnt_q == TMO_LAST) & ~act_ack;

   // DMEM writes bypass the controller entirely.
   assign dmem_we = ~hi & cpu_we;

   // Stall: reads wait for their data, new peripheral accesses wait for a
   // posted write to drain; DMEM and status accesses never wait.
   always_comb begin
      stall_c = 1'b0;
      case (state)
         S_IDLE:    stall_c = per_acc & ~cpu_we;
         S_WR_BUSY: stall_c = per_acc;
         S_RD_BUSY: stall_c = 1'b1;
         S_RD_DONE: stall_c = 1'b0;
      endcase
   end

   assign stall = stall_c & ~rst;

   // Transaction FSM with latched slot, data and wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         slot_q    <= 3'd0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         cnt_q     <= 8'd0;
         per_req_q <= 6'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (per_acc) begin
                  state     <= cpu_we ? S_WR_BUSY : S_RD_BUSY;
                  slot_q    <= slot_dec;
                  wdata_q   <= cpu_wdata;
                  cnt_q     <= 8'd0;
                  per_req_q <= 6'(1) << slot_dec;
               end
            end
            S_WR_BUSY: begin
               if (act_ack || tmo_hit) begin
                  state     <= S_IDLE;
                  per_req_q <= 6'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_RD_BUSY: begin
               if (act_ack) begin
                  state     <= S_RD_DONE;
                  rdata_q   <= per_rdata;
                  per_req_q <= 6'd0;
               end else if (tmo_hit) begin
                  state     <= S_RD_DONE;
                  rdata_q   <= 32'd0;
                  per_req_q <= 6'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_RD_DONE: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky error bits; a coinciding new error beats a status-write clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         unmapped_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         unmapped_err <= ((stat_wr & ~stall_c) ? 1'b0 : unmapped_err)
                         | (unm_acc & ~stall_c);
         timeout_err  <= ((stat_wr & ~stall_c) ? 1'b0 : timeout_err)
                         | (busy & tmo_hit);
      end
   end

   assign per_req   = rst ? 6'd0 : per_req_q;
   assign per_we    = ~rst & (state == S_WR_BUSY);
   assign per_wdata = (~rst & busy) ? wdata_q : 32'd0;

   // Read return: captured data for the single RD_DONE cycle, else status.
   always_comb begin
      cpu_rdata = 32'd0;
      if (!rst) begin
         if (state == S_RD_DONE)
            cpu_rdata = rdata_q;
         else if (stat_rd)
            cpu_rdata = {30'd0, unmapped_err, timeout_err};
      end
   end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Bench for mmio_bus_ctrl: directed scenarios followed by randomized CPU
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mmio_bus_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, per_wdata, per_rdata;
   logic        cpu_we, cpu_re, stall, dmem_we, per_we;
   logic [5:0]  per_req, per_ack;

   mmio_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_we(cpu_we), .cpu_re(cpu_re), .stall(stall), .cpu_rdata(cpu_rdata),
      .dmem_we(dmem_we), .per_req(per_req), .per_we(per_we),
      .per_wdata(per_wdata), .per_ack(per_ack), .per_rdata(per_rdata)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [11:0] slot_addr [6] = '{12'h800, 12'h804, 12'h814, 12'h81C, 12'h82C, 12'h830};
   logic [11:0] bad_addr  [4] = '{12'h8A0, 12'h808, 12'hFFC, 12'h801};

   // Model: at most one outstanding peripheral transaction plus a pending
   // read return, and the two sticky error flags.
   bit          m_busy, m_rd, m_done, m_unm, m_to, m_hold;
   int          m_slot, m_age;
   logic [31:0] m_data, m_ret;

   // Outputs observed in the most recent cycle.
   logic        o_stall, o_dmem, o_we;
   logic [5:0]  o_req;
   logic [31:0] o_rdata, o_wd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // -2: DMEM half, -1: unmapped, 0..5: slot, 6: status
   function automatic int slot_of(input logic [31:0] a);
      if (!a[11]) return -2;
      if (a[11:0] == 12'h8F0) return 6;
      for (int i = 0; i < 6; i++)
         if (a[11:0] == slot_addr[i]) return i;
      return -1;
   endfunction

   // One clock: drive, check outputs against the model, advance the model.
   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic [5:0] ack, input logic [31:0] prd,
                       input logic r);
      int s;
      bit per, to_set, clr, unm;
      logic e_stall, e_we;
      logic [5:0] e_req;
      logic [31:0] e_rd, e_wd;
      @(negedge clk);
      cpu_addr = a; cpu_wdata = wd; cpu_we = we; cpu_re = re;
      per_ack = ack; per_rdata = prd; rst = r;
      #1;
      o_stall = stall; o_dmem = dmem_we; o_we = per_we;
      o_req = per_req; o_rdata = cpu_rdata; o_wd = per_wdata;
      s   = slot_of(a);
      per = (s >= 0) && (s < 6) && (we || re);
      if (r) begin
         e_stall = 1'b0; e_req = 6'd0; e_we = 1'b0; e_wd = 32'd0; e_rd = 32'd0;
      end else begin
         e_req = m_busy ? 6'(1 << m_slot) : 6'd0;
         e_we  = m_busy && !m_rd;
         e_wd  = (m_busy && !m_rd) ? m_data : 32'd0;
         if (m_busy && m_rd) e_stall = 1'b1;
         else if (m_busy)    e_stall = per;
         else if (m_done)    e_stall = 1'b0;
         else                e_stall = per && !we;
         if (m_done) e_rd = m_ret;
         else if (s == 6 && re && !we) e_rd = {30'd0, m_unm, m_to};
         else e_rd = 32'd0;
      end
      chk("dmem_we", o_dmem, !a[11] && we);
      chk("stall", o_stall, e_stall);
      chk("per_req", o_req, e_req);
      chk("per_we", o_we, e_we);
      if (r || !(m_busy && m_rd)) chk("per_wdata", o_wd, e_wd);
      if (!r) chk("cpu_rdata", o_rdata, e_rd);
      m_hold = e_stall;
      if (r) begin
         m_busy = 0; m_done = 0; m_unm = 0; m_to = 0;
      end else begin
         to_set = 0;
         if (m_done) m_done = 0;
         else if (m_busy) begin
            if (ack[m_slot]) begin
               m_busy = 0;
               if (m_rd) begin m_done = 1; m_ret = prd; end
            end else if (m_age == TIMEOUT - 1) begin
               to_set = 1; m_busy = 0;
               if (m_rd) begin m_done = 1; m_ret = 32'd0; end
            end else m_age++;
         end else if (per) begin
            m_busy = 1; m_rd = !we; m_slot = s; m_data = wd; m_age = 0;
         end
         clr = (s == 6) && we && !e_stall;
         unm = (s == -1) && (we || re) && !e_stall;
         if (clr) begin m_unm = 0; m_to = 0; end
         if (unm) m_unm = 1;
         if (to_set) m_to = 1;
      end
   endtask

   task automatic nop(input logic [5:0] ack);
      step(32'd0, 32'd0, 1'b0, 1'b0, ack, 32'd0, 1'b0);
   endtask

   task automatic stat_read(input string tag, input logic [31:0] exp);
      step(32'h8F0, 32'd0, 1'b0, 1'b1, 6'd0, 32'd0, 1'b0);
      chk(tag, o_rdata, exp);
   endtask

   // Directed scenarios, then randomized traffic.
   initial begin
      int n, pct, k, sl;
      logic [31:0] a, wd;
      logic we, re, r;
      logic [5:0] ack;
      m_busy = 0; m_rd = 0; m_done = 0; m_unm = 0; m_to = 0; m_hold = 0;
      m_slot = 0; m_age = 0; m_data = 0; m_ret = 0;
      cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_re = 0;
      per_ack = 0; per_rdata = 0; rst = 1;

      // Reset state, with a DMEM store showing through during reset.
      step(32'h0000_0100, 32'h1, 1'b1, 1'b0, 6'h3F, 32'd0, 1'b1);
      chk("rst_dmem_we", o_dmem, 1'b1);
      step(32'h804, 32'h1, 1'b1, 1'b0, 6'd0, 32'd0, 1'b1);
      chk("rst_stall", o_stall, 1'b0);
      stat_read("rst_status", 32'd0);

      // Posted store to Seg, ack in cycle 3.
      step(32'h804, 32'h1234, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);
      chk("w_accept_stall", o_stall, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         nop((c == 3) ? 6'b000010 : 6'd0);
         chk("w_req", o_req, 6'b000010);
         chk("w_we", o_we, 1'b1);
         chk("w_wdata", o_wd, 32'h1234);
         chk("w_stall", o_stall, 1'b0);
      end
      nop(6'd0);
      chk("w_idle_req", o_req, 6'd0);

      // Store to VGA followed by a Timer load that waits for the write.
      step(32'h800, 32'h55, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         ack = (c == 2) ? 6'b000001 : (c == 6) ? 6'b000100 : 6'd0;
         step(32'h814, 32'd0, 1'b0, 1'b1, ack, (c == 6) ? 32'hCAFE : 32'hDEAD, 1'b0);
         if (c < 7) chk("wr_rd_stall", o_stall, 1'b1);
         if (c == 4) chk("wr_rd_req", o_req, 6'b000100);
      end
      chk("wr_rd_data", o_rdata, 32'hCAFE);
      chk("wr_rd_done_stall", o_stall, 1'b0);
      nop(6'd0);
      chk("wr_rd_after", o_rdata, 32'd0);

      // Read timeout on EthSendData: busy for TIMEOUT stalled cycles.
      step(32'h830, 32'd0, 1'b0, 1'b1, 6'd0, 32'd0, 1'b0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(32'h830, 32'd0, 1'b0, 1'b1, 6'b011111, 32'h9999, 1'b0);
         if (!o_stall) break;
         n++;
      end
      chk("tmo_busy_cycles", n, TIMEOUT);
      chk("tmo_rdata", o_rdata, 32'd0);
      stat_read("tmo_status", 32'h1);
      step(32'h8F0, 32'd0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);

      // Unmapped store, then clear via status write.
      step(32'h8A0, 32'h5, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);
      stat_read("unm_status", 32'h2);
      step(32'h8F0, 32'd0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);
      stat_read("clr_status", 32'h0);

      // DMEM store during a posted write; foreign ack ignored.
      step(32'h804, 32'hA5A5, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);
      step(32'h400, 32'h77, 1'b1, 1'b0, 6'b000100, 32'd0, 1'b0);
      chk("dmem_in_wr", o_dmem, 1'b1);
      chk("dmem_in_wr_stall", o_stall, 1'b0);
      nop(6'b000100);
      chk("foreign_ack_req", o_req, 6'b000010);
      nop(6'b000010);
      nop(6'd0);
      chk("foreign_ack_done", o_req, 6'd0);

      // Ack on the timeout boundary wins.
      step(32'h814, 32'd0, 1'b0, 1'b1, 6'd0, 32'd0, 1'b0);
      for (int c = 1; c <= TIMEOUT + 1; c++)
         step(32'h814, 32'd0, 1'b0, 1'b1, (c == TIMEOUT) ? 6'b000100 : 6'd0, 32'hBEEF, 1'b0);
      chk("edge_ack_data", o_rdata, 32'hBEEF);
      chk("edge_ack_stall", o_stall, 1'b0);
      stat_read("edge_ack_status", 32'h0);

      // Status-write clear coinciding with a write timeout.
      step(32'h8A0, 32'h5, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);
      step(32'h800, 32'h1, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);
      for (int c = 1; c < TIMEOUT; c++) nop(6'd0);
      step(32'h8F0, 32'd0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);
      stat_read("clr_vs_tmo", 32'h1);
      step(32'h8F0, 32'd0, 1'b1, 1'b0, 6'd0, 32'd0, 1'b0);

      // Reset in the second RD_BUSY cycle aborts the read.
      step(32'h804, 32'd0, 1'b0, 1'b1, 6'd0, 32'd0, 1'b0);
      step(32'h804, 32'd0, 1'b0, 1'b1, 6'd0, 32'd0, 1'b0);
      step(32'h804, 32'd0, 1'b0, 1'b1, 6'd0, 32'd0, 1'b1);
      nop(6'd0);
      chk("abort_req", o_req, 6'd0);
      chk("abort_stall", o_stall, 1'b0);
      stat_read("abort_status", 32'h0);

      // Randomized CPU traffic; a stalled access is held until released.
      pct = 50; a = 0; wd = 0; we = 0; re = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) begin
            k = $urandom_range(0, 2);
            pct = (k == 0) ? 50 : (k == 1) ? 8 : 0;
         end
         r = ($urandom_range(0, 299) == 0);
         if (!m_hold) begin
            k = $urandom_range(0, 9);
            if (k <= 2)      a = $urandom & 32'hFFFF_F7FC;
            else if (k <= 7) a = {$urandom_range(0, 15), 16'h0, 4'h0, slot_addr[$urandom_range(0, 5)]};
            else if (k == 8) a = 32'h0000_08F0;
            else             a = {20'h0, bad_addr[$urandom_range(0, 3)]};
            wd = $urandom;
            k = $urandom_range(0, 5);
            we = (k == 1) || (k == 2) || (k == 5);
            re = (k == 3) || (k == 4) || (k == 5);
         end
         ack = 6'($urandom & $urandom);
         if (m_busy) begin
            sl = m_slot;
            ack[sl] = ($urandom_range(0, 99) < pct);
         end
         step(a, wd, we, re, ack, $urandom, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_bus_ctrl.md
MMIO_BUS_CTRL -- requirements
Module: mmio_bus_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles a peripheral transaction waits for ack (range 2..255).
REQ-002 The module SHALL have these ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  32  CPU data address.
- cpu_wdata  in  32  store data.
- cpu_we  in  1  store strobe.
- cpu_re  in  1  load strobe.
- stall  out  1  freezes the CPU pipeline when high.
- cpu_rdata  out  32  load data for peripheral or status accesses.
- dmem_we  out  1  DMEM write enable.
- per_req  out  6  one-hot peripheral request.
- per_we  out  1  high for a write, low for a read.
- per_wdata  out  32  buffered store data.
- per_ack  in  6  per-slot acknowledge.
- per_rdata  in  32  peripheral read data, valid when the matching per_ack is high.

Function
REQ-003 Slot map on cpu_addr[11:0] SHALL be: 0x800=0 (VGA), 0x804=1 (Seg), 0x814=2 (Timer), 0x81C=3 (EthRst), 0x82C=4 (EthSendEna), 0x830=5 (EthSendData), 0x8F0=status register.
REQ-004 When cpu_addr[11]=0, dmem_we SHALL equal cpu_we combinationally, independent of the FSM, with no stall.
REQ-005 When cpu_addr[11]=1, dmem_we SHALL be 0.
REQ-006 Any other cpu_addr[11]=1 access SHALL be unmapped: write dropped, read returns 0, no stall, and sticky unmapped_err is set.
REQ-007 A status read SHALL return {30'b0, unmapped_err, timeout_err} combinationally, with no stall.
REQ-008 A status write SHALL clear both error bits on the next edge.
REQ-009 When cpu_we and cpu_re are both high, the access SHALL be treated as a write.
REQ-010 The FSM SHALL have states IDLE, WR_BUSY, RD_BUSY and RD_DONE.
REQ-011 IDLE + peripheral write: latch slot and cpu_wdata, go to WR_BUSY, stall=0 (posted write).
REQ-012 IDLE + peripheral read: latch slot, go to RD_BUSY, stall=1 in the same cycle.
REQ-013 In WR_BUSY and RD_BUSY, per_req[slot]=1 SHALL be driven from a register (first asserted the cycle after acceptance) and held until termination.
REQ-014 In those states, per_we=1 for WR_BUSY, 0 otherwise, and per_wdata SHALL hold the latched data.
REQ-015 WR_BUSY: per_ack[slot]=1 SHALL return the FSM to IDLE on the next edge.
REQ-016 WR_BUSY: any new peripheral access SHALL see stall=1 until the FSM is back in IDLE, then is accepted per REQ-011/012.
REQ-017 WR_BUSY: DMEM and status accesses SHALL proceed without stall.
REQ-018 RD_BUSY: stall=1.
REQ-019 RD_BUSY: per_ack[slot]=1 SHALL capture per_rdata into the read register and go to RD_DONE.
REQ-020 RD_DONE: stall=0, cpu_rdata = captured value for exactly one cycle, then IDLE.
REQ-021 per_ack bits for slots other than the active slot SHALL be ignored in all states.
REQ-022 A wait counter SHALL clear on entry to WR_BUSY/RD_BUSY and increment each busy cycle without ack.
REQ-023 When the counter reaches TIMEOUT-1 with no ack, timeout_err SHALL be set and the FSM SHALL go to IDLE (write) or RD_DONE with captured value 0 (read).
REQ-024 Ack in the same cycle as the timeout boundary SHALL win: normal completion, no error.
REQ-025 A status-write clear coinciding with a new error SHALL leave the new error bit set.
REQ-026 Outside RD_DONE and status reads, cpu_rdata SHALL be 0; per_req, per_we and per_wdata SHALL be 0 in IDLE and RD_DONE.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, counter=0, read register=0, both error bits=0.
REQ-028 While in reset: per_req=0, per_we=0, per_wdata=0, stall=0; dmem_we still follows REQ-004.
REQ-029 Reset during an in-flight transaction SHALL abort it: per_req drops the cycle after rst is sampled, with no ack awaited and no error set.

Verification
REQ-030 Store 0x1234 to 0x804, ack in cycle 3 -> stall never high; per_req=6'b000010, per_we=1, per_wdata=0x1234 for cycles 1..3; IDLE at cycle 4.
REQ-031 Store to 0x800, then a load from 0x814 next cycle, with the VGA ack at cycle 2 and Timer ack 0xCAFE 2 cycles after its req -> load stalls until FSM is IDLE, then RD_BUSY; cpu_rdata=0xCAFE for one cycle with stall=0.
REQ-032 Load from 0x830 with no ack, TIMEOUT=16 -> stall high for 16 cycles, cpu_rdata=0 in RD_DONE; status read returns 0x1.
REQ-033 Store to 0x8A0 then status read -> returns 0x2; status write, then status read -> returns 0x0.
REQ-034 Store to 0x400 during WR_BUSY -> dmem_we=1 the same cycle, stall=0; per_ack[2] during a slot-1 write is ignored.
REQ-035 rst asserted in RD_BUSY cycle 2 -> per_req=0 and stall=0 the next cycle; error bits remain 0.
